rx_bit_timer: RTL and testbench
===============================

// Module: rx_bit_timer
// PURPOSE
//  Parametrised receive bit-timing unit for the USB receiver datapath. Recovers bit timing from
//  an oversampled serial stream: resyncs the sample phase on every data edge, issues one
//  shift_enable per bit at a programmable sample point, counts bits into words and flags word
//  completion. Adds post-word holdoff and optional bit-stuff skipping. Sits between the
//  edge detector / decoder and the RX shift register / RCU.
// PARAMETERS
//  CLKS_PER_BIT   8  clk cycles per serial bit (>=4)
//  SAMPLE_POINT   3  phase value (0..CLKS_PER_BIT-1) at which the bit is sampled
//  BITS_PER_WORD  8  sampled bits per word (2..16)
//  HOLDOFF_CLKS   0  clk cycles phase counting is frozen after each word_received (0 = none)
//  STUFF_RUN      6  consecutive sampled 1s after which the next bit is a stuffed bit
// PORTS
//  clk            in   1   system clock
//  n_rst          in   1   asynchronous active-low reset
//  d_edge         in   1   one-cycle pulse: transition detected on the line
//  rcving         in   1   high while a packet is being received
//  d_orig         in   1   decoded data bit, valid on shift_enable cycles
//  shift_enable   out  1   one-cycle pulse: sample d_orig now
//  word_received  out  1   one-cycle pulse: BITS_PER_WORD bits shifted
//  bit_cnt        out  $clog2(BITS_PER_WORD+1)  bits shifted into current word
//  stuff_err      out  1   one-cycle pulse: stuffed-bit position sampled as 1
// BEHAVIOUR
//  - Reset: phase=0, bit_cnt=0, holdoff cnt=0, ones run=0; all outputs 0.
//  - Phase counter: 0..CLKS_PER_BIT-1, +1 per clk, wraps to 0. Cleared to 0 when d_edge or !rcving
//    (d_edge wins over increment/wrap). Frozen while holdoff count != 0; d_edge still clears it.
//  - shift_enable = rcving & (phase==SAMPLE_POINT) & (holdoff==0) & !stuff_slot; combinational
//    decode of registered state, so a d_edge in the same cycle does not suppress it.
//  - bit_cnt += 1 on shift_enable. On the shift_enable that makes bit_cnt==BITS_PER_WORD:
//    word_received registered high next cycle for exactly 1 cycle, bit_cnt returns to 0 that same
//    cycle, holdoff loaded with HOLDOFF_CLKS and decrements to 0 each clk.
//  - Holdoff: no shift_enable while nonzero; phase held. Back-to-back words legal when 0.
//  - !rcving (any time, incl. mid-word/mid-holdoff): next edge clears phase, bit_cnt, holdoff,
//    ones run; word_received and stuff_err forced 0; partial word discarded silently.
//  - rcving rising: counting starts from phase 0 that cycle; first sample SAMPLE_POINT clks later.
//  - Widths: phase $clog2(CLKS_PER_BIT); holdoff $clog2(HOLDOFF_CLKS+1) (min 1). No overflow
//    possible; elaborate-time $error if SAMPLE_POINT>=CLKS_PER_BIT.
// CONFIGURATION
//  RX_BIT_STUFF_EN defined: ones run counts consecutive d_orig=1 at shift_enable, reset on 0.
//    When run reaches STUFF_RUN, the next sample point is a stuff slot: no shift_enable, bit_cnt
//    unchanged, run cleared; if d_orig==1 there, stuff_err pulses 1 cycle later.
//  Not defined: d_orig ignored, stuff_slot=0, stuff_err tied 0, every sample point shifts.
// STRUCTURE
//  rx_timer_pkg: default parameter constants, phase/bit-count typedef widths helpers.
//  Bit counter reuses existing flex_counter (rollover_val=BITS_PER_WORD, clr on !rcving); phase,
//  holdoff and stuff logic local to this module. No other sub-modules.
// TESTING
//  1 Defaults, rcving=1, d_edge every 8 clks, 8 bits -> shift_enable at phase 3 each bit,
//    word_received 1 cycle after 8th shift, bit_cnt 0..8->0.
//  2 d_edge injected at phase 5 -> phase 0 next cycle, next shift_enable 3 clks after that edge.
//  3 HOLDOFF_CLKS=24, 2 words -> 24-cycle gap with no shift_enable, second word intact.
//  4 rcving dropped after 5 bits -> bit_cnt=0, no word_received; next packet counts from 0.
//  5 RX_BIT_STUFF_EN, data 1111110 + 1 -> 7th sample point skipped, stuff_err=0, word still 8 bits;
//    repeat with stuffed slot=1 -> stuff_err pulse once.
//  6 CLKS_PER_BIT=4, SAMPLE_POINT=1, BITS_PER_WORD=16 -> shift every 4 clks, word after 16.

Source files
------------

// File: rtl/rx_timer_pkg.sv
// rx_timer_pkg: shared defaults and width helpers for the RX bit-timing unit.
//   DEF_*     default parameter values for rx_bit_timer
//   bits_for  register width needed to hold 0..maxval (never less than 1)
package rx_timer_pkg;

  localparam int DEF_CLKS_PER_BIT  = 8;
  localparam int DEF_SAMPLE_POINT  = 3;
  localparam int DEF_BITS_PER_WORD = 8;
  localparam int DEF_HOLDOFF_CLKS  = 0;
  localparam int DEF_STUFF_RUN     = 6;

  function automatic int bits_for(input int maxval);
    int w;
    w = $clog2(maxval + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/flex_counter.sv
// flex_counter: enable-gated up counter that wraps to 0 on reaching rollover_val.
//   clk, n_rst     clock, async active-low reset
//   clear          synchronous clear of count and flag
//   count_enable   advance the count by one
//   rollover_val   count value at which the counter wraps (count returns to 0 on that step)
//   count_out      current count (never shows rollover_val)
//   rollover_flag  registered one-cycle pulse after the wrapping step
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);

  logic [NUM_CNT_BITS-1:0] count_q, count_d, last_val;
  logic                    flag_q, flag_d;

  assign last_val = rollover_val - NUM_CNT_BITS'(1);

  always_comb begin
    count_d = count_q;
    flag_d  = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (count_enable) begin
      if (count_q == last_val) begin
        count_d = '0;
        flag_d  = 1'b1;
      end else begin
        count_d = count_q + NUM_CNT_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
      flag_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      flag_q  <= flag_d;
    end
  end

  assign count_out     = count_q;
  assign rollover_flag = flag_q;

endmodule

// File: rtl/rx_bit_timer.sv
// rx_bit_timer: receive bit-timing recovery for the USB RX datapath.
// Resyncs the sample phase on each line edge, pulses shift_enable once per bit at
// SAMPLE_POINT, counts bits into words and pulses word_received per completed word.
// An optional post-word holdoff freezes phase counting for HOLDOFF_CLKS cycles.
// Optional feature macro: RX_BIT_STUFF_EN -- skip the sample point that follows
// STUFF_RUN consecutive sampled ones, flagging stuff_err if that slot reads 1.
// Ports:
//   clk, n_rst     clock, async active-low reset
//   d_edge         one-cycle pulse, line transition detected
//   rcving         high while a packet is being received
//   d_orig         decoded data bit, meaningful on sample points
//   shift_enable   one-cycle pulse: sample d_orig now
//   word_received  one-cycle pulse: BITS_PER_WORD bits have been shifted
//   bit_cnt        bits shifted into the current word
//   stuff_err      one-cycle pulse: stuffed-bit slot sampled as 1
module rx_bit_timer
  import rx_timer_pkg::*;
#(
  parameter int CLKS_PER_BIT  = DEF_CLKS_PER_BIT,
  parameter int SAMPLE_POINT  = DEF_SAMPLE_POINT,
  parameter int BITS_PER_WORD = DEF_BITS_PER_WORD,
  parameter int HOLDOFF_CLKS  = DEF_HOLDOFF_CLKS,
  parameter int STUFF_RUN     = DEF_STUFF_RUN
) (
  input  logic                                 clk,
  input  logic                                 n_rst,
  input  logic                                 d_edge,
  input  logic                                 rcving,
  input  logic                                 d_orig,
  output logic                                 shift_enable,
  output logic                                 word_received,
  output logic [$clog2(BITS_PER_WORD+1)-1:0]   bit_cnt,
  output logic                                 stuff_err
);

  localparam int PW = bits_for(CLKS_PER_BIT - 1);
  localparam int HW = bits_for(HOLDOFF_CLKS);
  localparam int CW = $clog2(BITS_PER_WORD + 1);

  if (SAMPLE_POINT >= CLKS_PER_BIT) begin : g_bad_sample_point
    $error("rx_bit_timer: SAMPLE_POINT must be below CLKS_PER_BIT");
  end

  logic [PW-1:0] phase_q, phase_d;
  logic [HW-1:0] holdoff_q, holdoff_d;
  logic          samp, stuff_slot, word_done;

  // Sample point reached; decoded from registered state only, so a d_edge in
  // this same cycle does not suppress the sample.
  assign samp         = rcving && (phase_q == PW'(SAMPLE_POINT)) && (holdoff_q == '0);
  assign shift_enable = samp && !stuff_slot;
  assign word_done    = shift_enable && (bit_cnt == CW'(BITS_PER_WORD - 1));

  always_comb begin
    phase_d = phase_q;
    if (!rcving || d_edge)                        phase_d = '0;
    else if (holdoff_q != '0)                     phase_d = phase_q;
    else if (phase_q == PW'(CLKS_PER_BIT - 1))    phase_d = '0;
    else                                          phase_d = phase_q + PW'(1);
  end

  always_comb begin
    holdoff_d = holdoff_q;
    if (!rcving)                holdoff_d = '0;
    else if (word_done)         holdoff_d = HW'(HOLDOFF_CLKS);
    else if (holdoff_q != '0)   holdoff_d = holdoff_q - HW'(1);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      phase_q   <= '0;
      holdoff_q <= '0;
    end else begin
      phase_q   <= phase_d;
      holdoff_q <= holdoff_d;
    end
  end

  // Wrap of the bit counter is the word boundary; its registered flag is word_received.
  flex_counter #(.NUM_CNT_BITS(CW)) u_bit_cnt (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (!rcving),
    .count_enable (shift_enable),
    .rollover_val (CW'(BITS_PER_WORD)),
    .count_out    (bit_cnt),
    .rollover_flag(word_received)
  );

`ifdef RX_BIT_STUFF_EN
  localparam int RW = bits_for(STUFF_RUN);

  logic [RW-1:0] ones_q, ones_d;
  logic          serr_q, serr_d;

  // The run never exceeds STUFF_RUN: the slot that follows always clears it.
  assign stuff_slot = (ones_q == RW'(STUFF_RUN));

  always_comb begin
    ones_d = ones_q;
    serr_d = 1'b0;
    if (!rcving) begin
      ones_d = '0;
    end else if (samp) begin
      if (stuff_slot) begin
        ones_d = '0;
        serr_d = d_orig;
      end else if (d_orig) begin
        ones_d = ones_q + RW'(1);
      end else begin
        ones_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ones_q <= '0;
      serr_q <= 1'b0;
    end else begin
      ones_q <= ones_d;
      serr_q <= serr_d;
    end
  end

  assign stuff_err = serr_q;
`else
  logic unused_d_orig;
  assign unused_d_orig = d_orig;
  assign stuff_slot    = 1'b0;
  assign stuff_err     = 1'b0;
`endif

endmodule

// File: tb/tb_rx_bit_timer.sv
// tb_rx_bit_timer: three rx_bit_timer configurations driven by shared inputs
// (defaults; 24-clock holdoff; 4 clk/bit, sample 1, 16-bit words), checked each
// cycle against an elapsed-time reference model, plus directed segment tables.
module tb_rx_bit_timer;

`ifdef RX_BIT_STUFF_EN
  localparam bit STUFF = 1'b1;
`else
  localparam bit STUFF = 1'b0;
`endif

  logic clk = 1'b0;
  logic n_rst, d_edge, rcving, d_orig;
  logic se0, se1, se2, wr0, wr1, wr2, er0, er1, er2;
  logic [3:0] cnt0, cnt1;
  logic [4:0] cnt2;

  always #5 clk = ~clk;

  rx_bit_timer u_a (
    .clk(clk), .n_rst(n_rst), .d_edge(d_edge), .rcving(rcving), .d_orig(d_orig),
    .shift_enable(se0), .word_received(wr0), .bit_cnt(cnt0), .stuff_err(er0));

  rx_bit_timer #(.HOLDOFF_CLKS(24)) u_b (
    .clk(clk), .n_rst(n_rst), .d_edge(d_edge), .rcving(rcving), .d_orig(d_orig),
    .shift_enable(se1), .word_received(wr1), .bit_cnt(cnt1), .stuff_err(er1));

  rx_bit_timer #(.CLKS_PER_BIT(4), .SAMPLE_POINT(1), .BITS_PER_WORD(16)) u_c (
    .clk(clk), .n_rst(n_rst), .d_edge(d_edge), .rcving(rcving), .d_orig(d_orig),
    .shift_enable(se2), .word_received(wr2), .bit_cnt(cnt2), .stuff_err(er2));

  int P_CPB[3] = '{8, 8, 4};
  int P_SP[3]  = '{3, 3, 1};
  int P_BPW[3] = '{8, 8, 16};
  int P_H[3]   = '{0, 24, 0};
  localparam int RUN = 6;

  int errors = 0, checks = 0, cyc = 0;

  // Reference state: el = un-frozen clocks since the last resync; phase is el mod CPB.
  int m_el[3], m_hold[3], m_ones[3], m_cnt[3], m_wr[3], m_err[3];
  // Observations of the DUT for directed totals.
  int n_sh[3], n_wr[3], n_er[3], last_cnt[3];
  int t_b[$], t_c[$];

  typedef struct {
    bit rcv; int clks; int edge_every; int edge_off;
    int exp_sh; int exp_wr; int exp_cnt;
  } seg_t;
  seg_t segs[5];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_el[i] = 0; m_hold[i] = 0; m_ones[i] = 0; m_cnt[i] = 0; m_wr[i] = 0; m_err[i] = 0;
    end
  endtask

  task automatic clr_obs();
    for (int i = 0; i < 3; i++) begin
      n_sh[i] = 0; n_wr[i] = 0; n_er[i] = 0; last_cnt[i] = 0;
    end
    t_b.delete(); t_c.delete();
  endtask

  task automatic step();
    int a_se[3], a_wr[3], a_cn[3], a_er[3];
    bit samp[3], slot[3], se_e[3];
    @(negedge clk);
    a_se = '{int'(se0), int'(se1), int'(se2)};
    a_wr = '{int'(wr0), int'(wr1), int'(wr2)};
    a_cn = '{int'(cnt0), int'(cnt1), int'(cnt2)};
    a_er = '{int'(er0), int'(er1), int'(er2)};
    for (int i = 0; i < 3; i++) begin
      samp[i] = rcving && (m_el[i] % P_CPB[i] == P_SP[i]) && (m_hold[i] == 0);
      slot[i] = STUFF && (m_ones[i] == RUN);
      se_e[i] = samp[i] && !slot[i];
      chk($sformatf("shift_enable[%0d]", i), a_se[i], int'(se_e[i]));
      chk($sformatf("word_received[%0d]", i), a_wr[i], m_wr[i]);
      chk($sformatf("bit_cnt[%0d]", i), a_cn[i], m_cnt[i]);
      chk($sformatf("stuff_err[%0d]", i), a_er[i], m_err[i]);
      n_sh[i] += a_se[i]; n_wr[i] += a_wr[i]; n_er[i] += a_er[i]; last_cnt[i] = a_cn[i];
    end
    if (se1) t_b.push_back(cyc);
    if (se2) t_c.push_back(cyc);
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (!n_rst || !rcving) begin
        m_el[i] = 0; m_hold[i] = 0; m_ones[i] = 0; m_cnt[i] = 0; m_wr[i] = 0; m_err[i] = 0;
      end else begin
        int old_hold;
        bit last;
        old_hold  = m_hold[i];
        last      = se_e[i] && (m_cnt[i] == P_BPW[i] - 1);
        m_wr[i]   = int'(last);
        m_err[i]  = int'(samp[i] && slot[i] && d_orig);
        if (last)             m_hold[i] = P_H[i];
        else if (m_hold[i] > 0) m_hold[i]--;
        if (se_e[i])          m_cnt[i] = (m_cnt[i] + 1) % P_BPW[i];
        if (STUFF && samp[i]) m_ones[i] = slot[i] ? 0 : (d_orig ? m_ones[i] + 1 : 0);
        if (d_edge)           m_el[i] = 0;
        else if (old_hold == 0) m_el[i]++;
      end
    end
    #1;
    cyc++;
  endtask

  initial begin
    bit pat[2][9];
    int drop;
    pat[0] = '{1, 1, 1, 1, 1, 1, 0, 1, 0};
    pat[1] = '{1, 1, 1, 1, 1, 1, 1, 0, 0};
    //          rcv clks every off  sh wr cnt
    segs[0] = '{1,  64,  8,   7,    8, 1, 0};   // nominal word, edge every bit
    segs[1] = '{1,  12, 16,   5,    2, 0, 2};   // edge at phase 5 resyncs
    segs[2] = '{1,  23,  0,   0,    3, 0, 5};   // partial word up to 5 bits
    segs[3] = '{0,   3,  0,   0,    0, 0, 0};   // drop rcving: partial word discarded
    segs[4] = '{1,  64,  8,   7,    8, 1, 0};   // next packet counts from 0

    n_rst = 1'b0; rcving = 1'b0; d_edge = 1'b0; d_orig = 1'b0;
    model_reset();
    repeat (3) step();
    n_rst = 1'b1;
    step();

    for (int s = 0; s < 5; s++) begin
      clr_obs();
      for (int k = 0; k < segs[s].clks; k++) begin
        rcving = segs[s].rcv;
        d_edge = (segs[s].edge_every > 0) && (k % segs[s].edge_every == segs[s].edge_off);
        step();
      end
      d_edge = 1'b0;
      chk($sformatf("seg%0d shifts", s), n_sh[0], segs[s].exp_sh);
      chk($sformatf("seg%0d words", s), n_wr[0], segs[s].exp_wr);
      chk($sformatf("seg%0d bit_cnt", s), last_cnt[0], segs[s].exp_cnt);
    end

    // Free-running packet: holdoff gap on u_b, 16-bit words on u_c.
    rcving = 1'b0; repeat (2) step();
    clr_obs();
    rcving = 1'b1;
    repeat (200) step();
    chk("free A shifts", n_sh[0], 25);
    chk("free A words", n_wr[0], 3);
    chk("holdoff B shifts", n_sh[1], 19);
    chk("holdoff B words", n_wr[1], 2);
    chk("holdoff B samples", t_b.size(), 19);
    if (t_b.size() >= 9) begin
      chk("holdoff B bit spacing", t_b[1] - t_b[0], 8);
      chk("holdoff B word gap", t_b[8] - t_b[7], 32);
    end
    chk("c4 C shifts", n_sh[2], 50);
    chk("c4 C words", n_wr[2], 3);
    if (t_c.size() >= 2) chk("c4 C spacing", t_c[1] - t_c[0], 4);

    // Six ones then the stuff slot (0 then 1).
    for (int p = 0; p < 2; p++) begin
      rcving = 1'b0; repeat (2) step();
      clr_obs();
      rcving = 1'b1;
      for (int k = 0; k < 70; k++) begin
        d_orig = pat[p][k / 8];
        step();
      end
      d_orig = 1'b0;
      chk($sformatf("stuff%0d shifts", p), n_sh[0], STUFF ? 8 : 9);
      chk($sformatf("stuff%0d words", p), n_wr[0], 1);
      chk($sformatf("stuff%0d errs", p), n_er[0], (STUFF && p == 1) ? 1 : 0);
    end

    // Randomized traffic against the model.
    drop = 0;
    rcving = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      if (drop > 0) begin
        drop--;
        rcving = 1'b0;
      end else if ($urandom % 80 == 0) begin
        drop = int'($urandom_range(1, 5));
        rcving = 1'b0;
      end else begin
        rcving = 1'b1;
      end
      d_edge = ($urandom % 10 == 0);
      d_orig = ($urandom % 4 != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
